// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM command port between camera write bursts, VGA read bursts and periodic refresh
module sdram_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int BURST_LEN    = 8,
    parameter int REF_INTERVAL = 390
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_next,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_done,
    output logic              ctl_cmd_valid,
    input  logic              ctl_cmd_ready,
    output logic [1:0]        ctl_cmd,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_done,
    input  logic [DATA_W-1:0] ctl_rdata,
    output logic              busy
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int RW = $clog2(REF_INTERVAL + 1);
    localparam logic [1:0] CMD_RD = 2'b00, CMD_WR = 2'b01, CMD_REF = 2'b10;

    typedef enum logic [2:0] {IDLE, REFRESH, WRITE, READ, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
    logic              ref_pending_q, ref_pending_d;
    logic              last_wr_q, last_wr_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_done_q, rd_done_d;
    logic              wr_done_q, wr_done_d;
    logic              ref_wrap, last_word, grant_wr;

    assign ref_wrap  = ref_cnt_q == RW'(REF_INTERVAL - 1);
    assign last_word = cnt_q == CW'(BURST_LEN - 1);
    assign grant_wr  = wr_req && (!rd_req || !last_wr_q);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            last_wr_q     <= 1'b1;
            op_q          <= CMD_RD;
            addr_q        <= '0;
            cnt_q         <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_done_q     <= 1'b0;
            wr_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            last_wr_q     <= last_wr_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            rd_done_q     <= rd_done_d;
            wr_done_q     <= wr_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        last_wr_d     = last_wr_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        rd_done_d     = 1'b0;
        wr_done_d     = 1'b0;
        ref_cnt_d     = ref_wrap ? '0 : ref_cnt_q + RW'(1);
        ref_pending_d = ref_wrap | (ref_pending_q & ~(state_q == REFRESH & ctl_cmd_ready));
        case (state_q)
            IDLE: begin
                if (ref_pending_q) begin
                    state_d = REFRESH;
                    op_d    = CMD_REF;
                end else if (rd_req || wr_req) begin
                    state_d = grant_wr ? WRITE : READ;
                    op_d    = grant_wr ? CMD_WR : CMD_RD;
                    addr_d  = grant_wr ? wr_addr : rd_addr;
                    cnt_d   = '0;
                end
            end
            REFRESH, WRITE, READ: state_d = ctl_cmd_ready ? WAIT_DONE : state_q;
            WAIT_DONE: begin
                if (ctl_done && op_q == CMD_REF) begin
                    state_d = IDLE;
                end else if (ctl_done) begin
                    addr_d     = addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q + CW'(1);
                    rd_valid_d = op_q == CMD_RD;
                    rd_data_d  = op_q == CMD_RD ? ctl_rdata : rd_data_q;
                    rd_done_d  = last_word && op_q == CMD_RD;
                    wr_done_d  = last_word && op_q == CMD_WR;
                    last_wr_d  = last_word ? op_q == CMD_WR : last_wr_q;
                    state_d    = last_word ? IDLE : (op_q == CMD_WR ? WRITE : READ);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctl_cmd_valid = state_q == REFRESH || state_q == WRITE || state_q == READ;
        ctl_cmd       = state_q == REFRESH ? CMD_REF : state_q == WRITE ? CMD_WR : CMD_RD;
        ctl_addr      = (state_q == WRITE || state_q == READ) ? addr_q : '0;
        ctl_wdata     = state_q == WRITE ? wr_data : '0;
        wr_next       = state_q == WRITE && ctl_cmd_ready;
        wr_done       = wr_done_q;
        rd_data       = rd_data_q;
        rd_valid      = rd_valid_q;
        rd_done       = rd_done_q;
        busy          = state_q != IDLE;
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench with a stalling controller model for sdram_arbiter
module tb_sdram_arbiter;
    localparam int AW = 24, DW = 16, BL = 8, RI = 390;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data;
    logic          wr_next, wr_done, rd_valid, rd_done;
    logic [DW-1:0] rd_data;
    logic          ctl_cmd_valid, ctl_cmd_ready, ctl_done, busy;
    logic [1:0]    ctl_cmd;
    logic [AW-1:0] ctl_addr;
    logic [DW-1:0] ctl_wdata, ctl_rdata;

    always #5 sys_clk = ~sys_clk;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .REF_INTERVAL(RI)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_next(wr_next), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
        .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready), .ctl_cmd(ctl_cmd),
        .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_done(ctl_done), .ctl_rdata(ctl_rdata),
        .busy(busy)
    );

    typedef struct {logic [1:0] cmd; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc;} cmd_t;
    typedef struct {logic [DW-1:0] data; logic last;} rd_t;

    cmd_t exp_cmd[$], obs_cmd[$], ref_obs[$];
    rd_t  exp_rd[$], obs_rd[$];
    int checks = 0, failures = 0;
    int cyc = 0, unstable = 0, bad_next = 0;
    int wr_next_cnt = 0, wr_done_cnt = 0, rd_done_cnt = 0;
    int stall_cfg = 0;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return a[15:0] ^ {a[23:16], 8'h5A};
    endfunction

    // controller: ready after stall_cfg cycles of valid, done 2 cycles after accept
    initial begin : ctl_model
        int wait_n, done_cnt;
        logic [DW-1:0] pend;
        wait_n = 0; done_cnt = 0; pend = '0;
        ctl_cmd_ready = 1'b0; ctl_done = 1'b0; ctl_rdata = '0; wr_data = 16'hA000;
        forever begin
            @(posedge sys_clk); #1;
            wr_data = DW'(16'hA000 + wr_next_cnt);
            ctl_done = 1'b0;
            if (rst) begin
                ctl_cmd_ready = 1'b0; wait_n = 0; done_cnt = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin ctl_done = 1'b1; ctl_rdata = pend; end
                end
                if (ctl_cmd_ready) begin
                    ctl_cmd_ready = 1'b0; done_cnt = 1;
                end else if (ctl_cmd_valid) begin
                    if (wait_n >= stall_cfg) begin ctl_cmd_ready = 1'b1; wait_n = 0; pend = mem(ctl_addr); end
                    else wait_n++;
                end
            end
        end
    end

    initial begin : monitor
        logic held;
        logic [1:0] hc;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        held = 1'b0; hc = '0; ha = '0; hd = '0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (rst) held = 1'b0;
            else begin
                if (ctl_cmd_valid && ctl_cmd_ready) begin
                    if (ctl_cmd == 2'b10) ref_obs.push_back('{ctl_cmd, ctl_addr, ctl_wdata, cyc});
                    else obs_cmd.push_back('{ctl_cmd, ctl_addr, ctl_wdata, cyc});
                end
                if (held && ctl_cmd_valid && {ctl_cmd, ctl_addr, ctl_wdata} !== {hc, ha, hd}) unstable++;
                held = ctl_cmd_valid && !ctl_cmd_ready; hc = ctl_cmd; ha = ctl_addr; hd = ctl_wdata;
                if (wr_next) begin
                    wr_next_cnt++;
                    if (!(ctl_cmd_valid && ctl_cmd_ready && ctl_cmd == 2'b01)) bad_next++;
                end
                if (wr_done) wr_done_cnt++;
                if (rd_done) rd_done_cnt++;
                if (rd_valid) obs_rd.push_back('{rd_data, rd_done});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(negedge sys_clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        exp_cmd.delete(); obs_cmd.delete(); ref_obs.delete(); exp_rd.delete(); obs_rd.delete();
    endtask

    task automatic push_burst(input logic [1:0] c, input logic [AW-1:0] a, input int wbase);
        for (int i = 0; i < BL; i++) begin
            exp_cmd.push_back('{c, AW'(a + AW'(i)), DW'(16'hA000 + wbase + i), 0});
            if (c == 2'b00) exp_rd.push_back('{mem(AW'(a + AW'(i))), i == BL - 1});
        end
    endtask

    task automatic wait_cmd(input logic [1:0] c, output bit ok);
        int n = 0;
        while (!(ctl_cmd_valid && ctl_cmd == c) && n < 200) begin tick(); n++; end
        ok = n < 200;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({ctl_cmd_valid, ctl_cmd, ctl_addr, ctl_wdata, wr_next, wr_done, rd_data, rd_valid, rd_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {ctl_cmd_valid, ctl_cmd, ctl_addr, ctl_wdata, wr_next, wr_done, rd_data, rd_valid, rd_done});
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_refresh();
        int n = 0;
        cmd_t r;
        while (ref_obs.size() == 0 && n < 450) begin tick(); n++; end
        checks++;
        if (n < 388 || n > 394) begin failures++; $display("FAIL refresh_time got=%0d exp=388..394", n); end
        while (n < 400) begin tick(); n++; end
        checks++;
        if (ref_obs.size() != 1) begin failures++; $display("FAIL refresh_count got=%0d exp=1", ref_obs.size()); end
        if (ref_obs.size() > 0) begin
            r = ref_obs.pop_front();
            checks++;
            if ({r.cmd, r.addr, r.data} !== {2'b10, AW'(0), DW'(0)}) begin
                failures++; $display("FAIL refresh_fields got=%0h/%0h/%0h exp=2/0/0", r.cmd, r.addr, r.data);
            end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL refresh_busy got=%b exp=0", busy); end
    endtask

    task automatic test_write();
        int nd0 = wr_done_cnt, nn0 = wr_next_cnt, n = 0;
        bit ok;
        cmd_t e, o;
        push_burst(2'b01, 24'h000100, wr_next_cnt);
        wr_addr = 24'h000100; wr_req = 1'b1;
        wait_cmd(2'b01, ok);
        wr_req = 1'b0;
        while (wr_done_cnt == nd0 && n < 300) begin tick(); n++; end
        repeat (4) tick();
        checks++;
        if (!ok || n >= 300) begin failures++; $display("FAIL write_timeout got=%0d exp=<300", n); end
        checks++;
        if (obs_cmd.size() != BL) begin failures++; $display("FAIL write_count got=%0d exp=%0d", obs_cmd.size(), BL); end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            e = exp_cmd.pop_front(); o = obs_cmd.pop_front();
            checks++;
            if ({o.cmd, o.addr, o.data} !== {e.cmd, e.addr, e.data}) begin
                failures++; $display("FAIL write_cmd got=%0h/%0h/%0h exp=%0h/%0h/%0h", o.cmd, o.addr, o.data, e.cmd, e.addr, e.data);
            end
        end
        checks++;
        if (wr_next_cnt - nn0 != BL || bad_next != 0) begin
            failures++; $display("FAIL write_next got=%0d bad=%0d exp=%0d bad=0", wr_next_cnt - nn0, bad_next, BL);
        end
        checks++;
        if (wr_done_cnt - nd0 != 1) begin failures++; $display("FAIL write_done got=%0d exp=1", wr_done_cnt - nd0); end
    endtask

    task automatic test_arbitration();
        int d0, n = 0, wb;
        cmd_t e, o;
        rd_t er, orr;
        do_reset();
        wb = wr_next_cnt;
        push_burst(2'b00, 24'h000200, 0);
        push_burst(2'b01, 24'h000300, wb);
        push_burst(2'b00, 24'h000200, 0);
        push_burst(2'b01, 24'h000300, wb + BL);
        d0 = rd_done_cnt + wr_done_cnt;
        rd_addr = 24'h000200; wr_addr = 24'h000300; rd_req = 1'b1; wr_req = 1'b1;
        while (rd_done_cnt + wr_done_cnt - d0 < 4 && n < 800) begin tick(); n++; end
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (4) tick();
        checks++;
        if (n >= 800 || obs_cmd.size() != 4 * BL) begin
            failures++; $display("FAIL arb_count got=%0d exp=%0d", obs_cmd.size(), 4 * BL);
        end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            e = exp_cmd.pop_front(); o = obs_cmd.pop_front();
            checks++;
            if (o.cmd !== e.cmd || o.addr !== e.addr || (e.cmd == 2'b01 && o.data !== e.data)) begin
                failures++; $display("FAIL arb_cmd got=%0h/%0h/%0h exp=%0h/%0h/%0h", o.cmd, o.addr, o.data, e.cmd, e.addr, e.data);
            end
        end
        checks++;
        if (obs_rd.size() != exp_rd.size()) begin failures++; $display("FAIL arb_rd_count got=%0d exp=%0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            er = exp_rd.pop_front(); orr = obs_rd.pop_front();
            checks++;
            if ({orr.data, orr.last} !== {er.data, er.last}) begin
                failures++; $display("FAIL arb_rd got=%0h/%b exp=%0h/%b", orr.data, orr.last, er.data, er.last);
            end
        end
    endtask

    task automatic test_addr_wrap();
        int d0 = rd_done_cnt, n = 0;
        bit ok;
        cmd_t e, o;
        rd_t er, orr;
        obs_cmd.delete(); obs_rd.delete();
        push_burst(2'b00, 24'hFFFFFE, 0);
        rd_addr = 24'hFFFFFE; rd_req = 1'b1;
        wait_cmd(2'b00, ok);
        rd_req = 1'b0;
        while (rd_done_cnt == d0 && n < 300) begin tick(); n++; end
        repeat (4) tick();
        checks++;
        if (!ok || n >= 300 || obs_cmd.size() != BL) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", obs_cmd.size(), BL); end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            e = exp_cmd.pop_front(); o = obs_cmd.pop_front();
            checks++;
            if (o.cmd !== e.cmd || o.addr !== e.addr) begin
                failures++; $display("FAIL wrap_cmd got=%0h/%0h exp=%0h/%0h", o.cmd, o.addr, e.cmd, e.addr);
            end
        end
        checks++;
        if (obs_rd.size() != BL || rd_done_cnt - d0 != 1) begin
            failures++; $display("FAIL wrap_rd got=%0d/%0d exp=%0d/1", obs_rd.size(), rd_done_cnt - d0, BL);
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            er = exp_rd.pop_front(); orr = obs_rd.pop_front();
            checks++;
            if ({orr.data, orr.last} !== {er.data, er.last}) begin
                failures++; $display("FAIL wrap_rd_data got=%0h/%b exp=%0h/%b", orr.data, orr.last, er.data, er.last);
            end
        end
    endtask

    task automatic test_refresh_mid();
        int d0, n = 0, u0, wr_last, rd_first, rf;
        bit ok;
        cmd_t e, o;
        do_reset();
        stall_cfg = 3;
        u0 = unstable;
        repeat (370) tick();
        ref_obs.delete();
        push_burst(2'b01, 24'h000600, wr_next_cnt);
        push_burst(2'b00, 24'h000700, 0);
        d0 = rd_done_cnt;
        wr_addr = 24'h000600; wr_req = 1'b1;
        wait_cmd(2'b01, ok);
        wr_req = 1'b0;
        rd_addr = 24'h000700; rd_req = 1'b1;
        while (rd_done_cnt == d0 && n < 600) begin tick(); n++; end
        rd_req = 1'b0;
        repeat (4) tick();
        stall_cfg = 0;
        checks++;
        if (!ok || n >= 600 || obs_cmd.size() != 2 * BL || ref_obs.size() != 1) begin
            failures++; $display("FAIL refmid_count got=%0d/%0d exp=%0d/1", obs_cmd.size(), ref_obs.size(), 2 * BL);
        end else begin
            wr_last = obs_cmd[BL-1].cyc; rd_first = obs_cmd[BL].cyc; rf = ref_obs[0].cyc;
            checks++;
            if (!(rf > wr_last && rf < rd_first)) begin
                failures++; $display("FAIL refmid_order got=%0d exp=%0d..%0d", rf, wr_last, rd_first);
            end
        end
        checks++;
        if (unstable != u0) begin failures++; $display("FAIL refmid_stable got=%0d exp=0", unstable - u0); end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            e = exp_cmd.pop_front(); o = obs_cmd.pop_front();
            checks++;
            if (o.cmd !== e.cmd || o.addr !== e.addr || (e.cmd == 2'b01 && o.data !== e.data)) begin
                failures++; $display("FAIL refmid_cmd got=%0h/%0h/%0h exp=%0h/%0h/%0h", o.cmd, o.addr, o.data, e.cmd, e.addr, e.data);
            end
        end
        exp_rd.delete(); obs_rd.delete();
    endtask

    task automatic test_reset_mid();
        int d0, n = 0;
        bit ok;
        cmd_t e, o;
        do_reset();
        stall_cfg = 3;
        for (int i = 0; i < 3; i++) exp_cmd.push_back('{2'b00, AW'(24'h000400 + i), '0, 0});
        rd_addr = 24'h000400; rd_req = 1'b1;
        wait_cmd(2'b00, ok);
        rd_req = 1'b0;
        while (!(obs_cmd.size() == 3 && ctl_cmd_valid) && n < 300) begin tick(); n++; end
        checks++;
        if (!ok || n >= 300) begin failures++; $display("FAIL rstmid_timeout got=%0d exp=<300", n); end
        d0 = rd_done_cnt;
        rst = 1'b1;
        tick();
        checks++;
        if ({ctl_cmd_valid, ctl_cmd, ctl_addr, ctl_wdata, wr_next, wr_done, rd_data, rd_valid, rd_done, busy} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%0h exp=0", {ctl_cmd_valid, ctl_cmd, ctl_addr, ctl_wdata, wr_next, wr_done, rd_data, rd_valid, rd_done, busy});
        end
        rst = 1'b0;
        stall_cfg = 0;
        repeat (20) tick();
        checks++;
        if (rd_done_cnt != d0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_nodone got=%0d/%b exp=0/0", rd_done_cnt - d0, busy); end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            e = exp_cmd.pop_front(); o = obs_cmd.pop_front();
            checks++;
            if (o.cmd !== e.cmd || o.addr !== e.addr) begin
                failures++; $display("FAIL rstmid_cmd got=%0h/%0h exp=%0h/%0h", o.cmd, o.addr, e.cmd, e.addr);
            end
        end
        obs_cmd.delete(); obs_rd.delete();
        push_burst(2'b00, 24'h000500, 0);
        d0 = rd_done_cnt; n = 0;
        rd_addr = 24'h000500; rd_req = 1'b1;
        wait_cmd(2'b00, ok);
        rd_req = 1'b0;
        while (rd_done_cnt == d0 && n < 300) begin tick(); n++; end
        repeat (4) tick();
        checks++;
        if (!ok || n >= 300 || obs_cmd.size() != BL || obs_rd.size() != BL) begin
            failures++; $display("FAIL rstmid_restart got=%0d/%0d exp=%0d/%0d", obs_cmd.size(), obs_rd.size(), BL, BL);
        end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            e = exp_cmd.pop_front(); o = obs_cmd.pop_front();
            checks++;
            if (o.cmd !== e.cmd || o.addr !== e.addr) begin
                failures++; $display("FAIL rstmid_new_cmd got=%0h/%0h exp=%0h/%0h", o.cmd, o.addr, e.cmd, e.addr);
            end
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            rd_t er = exp_rd.pop_front();
            rd_t orr = obs_rd.pop_front();
            checks++;
            if ({orr.data, orr.last} !== {er.data, er.last}) begin
                failures++; $display("FAIL rstmid_rd got=%0h/%b exp=%0h/%b", orr.data, orr.last, er.data, er.last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_write();
        test_arbitration();
        test_addr_wrap();
        test_refresh_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single SDRAM controller command port between the camera write path (pixel FIFO drain) and the VGA read path (line prefetch). Inserts periodic auto-refresh commands on its own timer. Sits between the capture/display FIFOs and the SDRAM controller in top, all on sys_clk (50 MHz). Each grant moves one fixed-length burst of single-word commands at consecutive addresses.

Parameters:
ADDR_W, 24, SDRAM word address width (bank+row+col)
DATA_W, 16, SDRAM data width
BURST_LEN, 8, words per granted burst (1..256)
REF_INTERVAL, 390, sys_clk cycles between refresh requests (7.8 us at 50 MHz)

Ports:
sys_clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
wr_req  in  1  camera side has >= BURST_LEN words ready; level
wr_addr  in  ADDR_W  burst start address, sampled at grant
wr_data  in  DATA_W  current write word (show-ahead FIFO head)
wr_next  out  1  1-cycle pulse: current wr_data consumed, advance FIFO
wr_done  out  1  1-cycle pulse: write burst complete
rd_req  in  1  display side wants a burst; level
rd_addr  in  ADDR_W  burst start address, sampled at grant
rd_data  out  DATA_W  read word
rd_valid  out  1  1-cycle pulse: rd_data valid
rd_done  out  1  1-cycle pulse: read burst complete
ctl_cmd_valid  out  1  command valid to controller
ctl_cmd_ready  in  1  controller accepts command
ctl_cmd  out  2  00 read, 01 write, 10 refresh
ctl_addr  out  ADDR_W  command address
ctl_wdata  out  DATA_W  write data
ctl_done  in  1  1-cycle pulse: accepted command finished
ctl_rdata  in  DATA_W  read data, valid with ctl_done on reads
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (sys_clk); reset is synchronous and active-high (rst).
- Reset: state IDLE; all outputs 0; refresh counter 0, ref_pending 0; last-served = write (so read wins first tie). Reset mid-burst abandons the burst immediately; no done pulse.
- States: IDLE, REFRESH, WRITE, READ, WAIT_DONE.
- Refresh timer: counts every cycle regardless of state; at count == REF_INTERVAL-1 wraps to 0 and sets ref_pending. ref_pending clears on refresh command handshake. Timer expiring while ref_pending already set: no effect (no stacking).
- IDLE arbitration, priority: ref_pending > round-robin(rd_req, wr_req). Both requests: grant the one not last served. Decision in the cycle of the request; ctl_cmd_valid asserts the next cycle.
- Grant: latch start address into address counter, word counter = 0, record direction.
- Command issue: ctl_cmd_valid, ctl_cmd, ctl_addr, ctl_wdata held stable until ctl_cmd_ready; handshake cycle = valid & ready. Then go WAIT_DONE with valid low; only one command outstanding.
- Write handshake: wr_next pulses in the handshake cycle; ctl_wdata = wr_data for the current word (requester presents next word by the following cycle).
- WAIT_DONE on ctl_done: read -> rd_data = ctl_rdata, rd_valid pulse (registered, 1 cycle after ctl_done). Increment address (mod 2^ADDR_W, wraps 2^ADDR_W-1 -> 0) and word counter. If word counter reaches BURST_LEN: done pulse (rd_done coincides with the last rd_valid; wr_done 1 cycle after last ctl_done), update last-served, return IDLE. Else reissue same direction.
- Refresh: ctl_cmd = 10, addr 0, data 0; on ctl_done return IDLE. Refresh never preempts a burst; it waits for burst end. Worst-case delay is bounded by BURST_LEN commands.
- Requests dropped mid-burst are ignored; the burst completes. Requests are sampled only in IDLE.
- ctl_done outside WAIT_DONE is ignored.

Test Plan:
- Reset then idle 400 cycles, controller ready=1, done 2 cycles after accept -> refresh command (ctl_cmd=10) at cycle 390 after reset, ref_pending cleared, busy back low.
- wr_req with wr_addr=0x000100, data 0xA000..0xA007 -> 8 write commands addr 0x100..0x107 with matching data, 8 wr_next pulses, one wr_done.
- rd_req and wr_req asserted same cycle after reset -> read burst first, then write burst; repeat -> alternation continues.
- rd_addr=0xFFFFFE, BURST_LEN=8 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000..0x000005; 8 rd_valid, rd_done with the 8th.
- Refresh timer expires mid-write burst, ctl_cmd_ready stalled 3 cycles per command -> command fields stable during stall, burst finishes, refresh issued before the next granted burst.
- rst asserted during 4th read command -> next cycle all outputs 0, state IDLE, no rd_done; new rd_req after reset restarts from the latched new address.
